// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
//
// Front end of the PDM microphone path. It generates the microphone bit clock,
// captures the 1-bit PDM stream, and decimates it with a 3rd-order CIC filter
// (differential delay 1, ratio 2^DECIM_LOG2) into 8-bit unsigned PCM samples.
// sample_out / sample_valid feed the circular sample buffer directly as write
// data / write strobe. There is no backpressure.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   en           in   run enable; low freezes divider, counters and filter state
//   pdm_data     in   PDM bit from the microphone
//   pdm_clk      out  bit clock to the microphone (registered)
//   sample_out   out  8-bit unsigned PCM sample, held between strobes
//   sample_valid out  one-cycle strobe qualifying sample_out
//
// Handshake: sample_valid is a pure valid with no ready. Each high cycle
// carries exactly one new sample on sample_out, and the consumer must take it
// in that cycle.
// -----------------------------------------------------------------------------
module pdm_cic_decimator #(
  parameter int CLK_DIV    = 8,
  parameter int DECIM_LOG2 = 5,
  parameter int ACC_W      = 3 * DECIM_LOG2 + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pdm_data,
  output logic       pdm_clk,
  output logic [7:0] sample_out,
  output logic       sample_valid
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HALF  = CLK_DIV / 2;

  // Clock divider and bit-clock generation
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pdm_clk_q;

  // Input capture and decimation bookkeeping
  logic                  pdm_q;
  logic [DECIM_LOG2-1:0] dec_cnt_q;
  logic [1:0]            warm_cnt_q;

  // CIC integrators, comb delays, and the top 9 bits of the comb result
  logic [ACC_W-1:0] i1_q, i2_q, i3_q;
  logic [ACC_W-1:0] i1_d, i2_d, i3_d;
  logic [ACC_W-1:0] d1_q, d2_q, d3_q;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [8:0]       r_q;

  // Pipeline flags: s1 = comb stage pending, emit = result will be presented
  logic s1_q, s1_emit_q, s2_emit_q;

  logic [7:0] sample_out_q;
  logic       sample_valid_q;

  logic bit_stb;
  logic dec_evt;
  logic [7:0] sat_val;

  // Divider advances only while enabled; holding it also holds pdm_clk.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) begin
      if (div_cnt_q == DIV_W'(CLK_DIV - 1)) div_cnt_d = '0;
      else                                  div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Bit strobe on the last low cycle before the pdm_clk rising edge; the
  // microphone drives its bit after the falling edge, so data is settled here.
  assign bit_stb = en && (div_cnt_q == DIV_W'(HALF - 1));
  assign dec_evt = bit_stb && (dec_cnt_q == {DECIM_LOG2{1'b1}});

  // Integrator chain: each stage adds the pre-update value of the stage
  // before it, so the chain carries two bit periods of latency. Wrap is
  // intentional; the combs cancel it.
  always_comb begin
    i1_d = i1_q + ACC_W'(pdm_q);
    i2_d = i2_q + i1_q;
    i3_d = i3_q + i2_q;
  end

  // Comb chain, evaluated in the cycle after a decimation event.
  always_comb begin
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
  end

  // Full scale is exactly 2^(ACC_W-1), the only value with the MSB set, so
  // the MSB alone selects saturation to 255.
  assign sat_val = r_q[8] ? 8'hFF : r_q[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q      <= '0;
      pdm_clk_q      <= 1'b0;
      pdm_q          <= 1'b0;
      dec_cnt_q      <= '0;
      warm_cnt_q     <= '0;
      i1_q           <= '0;
      i2_q           <= '0;
      i3_q           <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      d3_q           <= '0;
      r_q            <= '0;
      s1_q           <= 1'b0;
      s1_emit_q      <= 1'b0;
      s2_emit_q      <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= (div_cnt_d >= DIV_W'(HALF));
      pdm_q     <= pdm_data;

      if (bit_stb) begin
        i1_q      <= i1_d;
        i2_q      <= i2_d;
        i3_q      <= i3_d;
        dec_cnt_q <= dec_cnt_q + 1'b1;
      end

      // The first three results are CIC start-up transient and are dropped.
      if (dec_evt && (warm_cnt_q != 2'd3)) warm_cnt_q <= warm_cnt_q + 1'b1;

      // Pipeline flags run independently of en so an in-flight result still
      // completes while the front end is frozen.
      s1_q      <= dec_evt;
      s1_emit_q <= dec_evt && (warm_cnt_q == 2'd3);
      s2_emit_q <= s1_emit_q;

      if (s1_q) begin
        d1_q <= i3_q;
        d2_q <= c1;
        d3_q <= c2;
        r_q  <= c3[ACC_W-1:ACC_W-9];
      end

      sample_valid_q <= s2_emit_q;
      if (s2_emit_q) sample_out_q <= sat_val;
    end
  end

  assign pdm_clk      = pdm_clk_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;

endmodule
